// File: rtl/memory_fifo_pkg.sv
// memory_fifo_pkg: address-width and wrap-bit pointer helpers for memory_fifo_ctrl
package memory_fifo_pkg;
  function automatic int addr_w(input int lines);
    return $clog2(lines) + 1;
  endfunction
  function automatic logic [31:0] ptr_occ(input logic [31:0] w, input logic [31:0] r, input int aw);
    return (w - r) & ((32'd1 << aw) - 32'd1);
  endfunction
  function automatic logic ptrs_full(input logic [31:0] w, input logic [31:0] r, input int aw);
    return (w ^ r) == (32'd1 << (aw - 1));
  endfunction
endpackage

// File: rtl/memory_fifo_ctrl_if.sv
// memory_fifo_ctrl_if: stream, memory and status signals of memory_fifo_ctrl
interface memory_fifo_ctrl_if import memory_fifo_pkg::*; #(parameter int LINES_NUM = 8, parameter int DATA_WIDTH = 4);
  localparam int ADDR_W = addr_w(LINES_NUM);
  logic in_valid, in_ready, out_valid, out_ready, mem_wr_en, mem_rd_en, full, empty;
  logic [DATA_WIDTH-1:0] in_data, out_data, mem_wr_data, mem_rd_data;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr, count;
  modport slave (
    input in_valid, in_data, out_ready, mem_rd_data,
    output in_ready, out_valid, out_data, mem_wr_en, mem_wr_addr, mem_wr_data,
    mem_rd_en, mem_rd_addr, count, full, empty
  );
  modport master (
    output in_valid, in_data, out_ready, mem_rd_data,
    input in_ready, out_valid, out_data, mem_wr_en, mem_wr_addr, mem_wr_data,
    mem_rd_en, mem_rd_addr, count, full, empty
  );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer, MSB toggles each time the index bits wrap
module fifo_ptr #(parameter int W = 4) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else ptr <= ptr + W'(inc);
endmodule

// File: rtl/memory_fifo_ctrl.sv
// memory_fifo_ctrl: valid/ready FIFO over an external memory with a one-word prefetch register
module memory_fifo_ctrl import memory_fifo_pkg::*; #(parameter int LINES_NUM = 8, parameter int DATA_WIDTH = 4) (
  input logic clk,
  input logic rst,
  memory_fifo_ctrl_if.slave bus
);
  localparam int ADDR_W = addr_w(LINES_NUM);
  logic [ADDR_W-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid, mem_full, mem_empty, push, load, pop;
  fifo_ptr #(.W(ADDR_W)) u_wptr (.clk(clk), .rst(rst), .inc(push), .ptr(wptr));
  fifo_ptr #(.W(ADDR_W)) u_rptr (.clk(clk), .rst(rst), .inc(load), .ptr(rptr));
  assign mem_full  = ptrs_full(32'(wptr), 32'(rptr), ADDR_W);
  assign mem_empty = wptr == rptr;
  assign push = bus.in_valid && !mem_full;
  assign load = !mem_empty && (!out_valid || bus.out_ready);
  assign pop  = out_valid && bus.out_ready;
  assign bus.in_ready    = !mem_full;
  assign bus.mem_wr_en   = push;
  assign bus.mem_wr_addr = {1'b0, wptr[ADDR_W-2:0]};
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_rd_en   = load;
  assign bus.mem_rd_addr = {1'b0, rptr[ADDR_W-2:0]};
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.count       = ADDR_W'(ptr_occ(32'(wptr), 32'(rptr), ADDR_W)) + ADDR_W'(out_valid);
  assign bus.full        = mem_full;
  assign bus.empty       = bus.count == '0;
  // a load refills the register even while it is being popped, so no bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= bus.mem_rd_data;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_memory_fifo_ctrl.sv
// tb_memory_fifo_ctrl: directed and random checks of memory_fifo_ctrl against a queue model
module tb_memory_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  memory_fifo_ctrl_if #(.LINES_NUM(8), .DATA_WIDTH(4)) b ();
  memory_fifo_ctrl #(.LINES_NUM(8), .DATA_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;

  logic [3:0] mem [8];
  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 8; i++) mem[i] <= '0;
    else if (b.mem_wr_en) mem[b.mem_wr_addr[2:0]] <= b.mem_wr_data;
  assign b.mem_rd_data = b.mem_rd_en ? mem[b.mem_rd_addr[2:0]] : 4'h0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  logic [3:0] q[$];
  bit m_ov, m_push, m_load;
  logic [3:0] m_od;
  int wcnt, rcnt;
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      m_ov = 0; m_od = 0; wcnt = 0; rcnt = 0;
    end else begin
      m_push = b.in_valid && q.size() < 8;
      m_load = q.size() > 0 && (!m_ov || b.out_ready);
      if (m_load) begin
        m_od = q.pop_front();
        m_ov = 1;
        rcnt++;
      end else if (m_ov && b.out_ready) m_ov = 0;
      if (m_push) begin
        q.push_back(b.in_data);
        wcnt++;
      end
    end

  int sz;
  bit c_push, c_load;
  always @(negedge clk)
    if (!rst) begin
      sz = q.size();
      c_push = b.in_valid && sz < 8;
      c_load = sz > 0 && (!m_ov || b.out_ready);
      chk("in_ready", 32'(b.in_ready), 32'(sz < 8));
      chk("out_valid", 32'(b.out_valid), 32'(m_ov));
      chk("out_data", 32'(b.out_data), 32'(m_od));
      chk("count", 32'(b.count), 32'(sz + int'(m_ov)));
      chk("full", 32'(b.full), 32'(sz == 8));
      chk("empty", 32'(b.empty), 32'(sz == 0 && !m_ov));
      chk("mem_wr_en", 32'(b.mem_wr_en), 32'(c_push));
      chk("mem_rd_en", 32'(b.mem_rd_en), 32'(c_load));
      chk("mem_wr_addr", 32'(b.mem_wr_addr), 32'(wcnt % 8));
      chk("mem_rd_addr", 32'(b.mem_rd_addr), 32'(rcnt % 8));
      if (c_push) chk("mem_wr_data", 32'(b.mem_wr_data), 32'(b.in_data));
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] got[$];
  int p_in, p_out;
  initial begin
    b.in_valid = 0; b.in_data = 0; b.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(b.in_ready), 1);
    chk("rst_out_valid", 32'(b.out_valid), 0);
    chk("rst_empty", 32'(b.empty), 1);
    chk("rst_full", 32'(b.full), 0);
    chk("rst_count", 32'(b.count), 0);
    chk("rst_wr_en", 32'(b.mem_wr_en), 0);
    chk("rst_rd_en", 32'(b.mem_rd_en), 0);
    chk("rst_addrs", {b.mem_wr_addr, b.mem_rd_addr}, 0);
    rst = 0;
    step();
    b.in_valid = 1; b.in_data = 4'hA;
    #1;
    chk("t2_wr", {b.mem_wr_en, b.mem_wr_addr, b.mem_wr_data}, {1'b1, 4'd0, 4'hA});
    step();
    b.in_valid = 0;
    #1;
    chk("t2_rd", {b.mem_rd_en, b.mem_rd_addr, b.out_valid}, {1'b1, 4'd0, 1'b0});
    step();
    chk("t2_out", {b.out_valid, b.out_data, b.count}, {1'b1, 4'hA, 4'd1});
    b.out_ready = 1;
    step();
    b.out_ready = 0;
    #1;
    chk("t2_drained", 32'(b.empty), 1);
    for (int i = 0; i < 9; i++) begin
      b.in_valid = 1; b.in_data = 4'(i);
      step();
    end
    b.in_data = 4'hF;
    #1;
    chk("t3_state", {b.out_data, b.full, b.in_ready, b.count}, {4'h0, 1'b1, 1'b0, 4'd9});
    chk("t3_reject", 32'(b.mem_wr_en), 0);
    step();
    b.in_valid = 0;
    #1;
    chk("t3_count_held", 32'(b.count), 9);
    b.out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t4_out_data", {b.out_valid, b.out_data}, {1'b1, 4'(i)});
      chk("t4_in_ready", 32'(b.in_ready), 32'(i != 0));
      step();
    end
    #1;
    chk("t4_empty", 32'(b.empty), 1);
    for (int i = 0; i < 24; i++) begin
      b.in_valid = i < 20; b.in_data = 4'(i % 16);
      #1;
      if (i < 20) chk("t5_wr_addr", 32'(b.mem_wr_addr), 32'((10 + i) % 8));
      chk("t5_addr_msb", {b.mem_wr_addr[3], b.mem_rd_addr[3]}, 0);
      if (b.count > 2) chk("t5_count_le2", 32'(b.count), 2);
      if (b.out_valid) got.push_back(b.out_data);
      step();
    end
    chk("t5_num_words", 32'(got.size()), 20);
    for (int i = 0; i < got.size(); i++) chk("t5_order", 32'(got[i]), 32'(i % 16));
    b.in_valid = 0; b.out_ready = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      b.in_valid = 1; b.in_data = 4'(i + 1);
      step();
    end
    #2;
    b.in_valid = 0;
    rst = 1;
    #1;
    chk("t6_rst_out", {b.out_valid, b.out_data, b.count}, 0);
    chk("t6_rst_flags", {b.empty, b.full, b.in_ready, b.mem_wr_en, b.mem_rd_en}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("t6_rst_addrs", {b.mem_wr_addr, b.mem_rd_addr}, 0);
    #2;
    rst = 0;
    step();
    b.in_valid = 1; b.in_data = 4'h3;
    step();
    b.in_valid = 0;
    step();
    chk("t6_first_word", {b.out_valid, b.out_data}, {1'b1, 4'h3});
    for (int s = 0; s < 8; s++) begin
      p_in = $urandom_range(1, 9);
      p_out = $urandom_range(1, 9);
      for (int i = 0; i < 50; i++) begin
        b.in_valid = $urandom_range(0, 9) < p_in;
        b.in_data = 4'($urandom);
        b.out_ready = $urandom_range(0, 9) < p_out;
        step();
      end
    end
    b.in_valid = 0; b.out_ready = 0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_fifo_ctrl.md
Name: memory_fifo_ctrl

Overview:
- Initiator-side controller for the team's `memory` block (LINES_NUM x DATA_WIDTH, registered write, combinational read gated by rd_en).
- Drives the memory's wr_en/wr_addr/wr_data and rd_en/rd_addr, and consumes rd_data.
- Presents a valid/ready streaming FIFO to the surrounding logic.
- Holds a one-entry output register, so total capacity is LINES_NUM+1.

Parameters:
- LINES_NUM, 8, memory depth; power of two, >= 2.
- DATA_WIDTH, 4, data word width.
- ADDR_W (localparam), $clog2(LINES_NUM)+1, memory address port width; matches the memory's address ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  producer has a word
- in_ready  out  1  controller accepts a word
- in_data  in  DATA_WIDTH  producer word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer takes the word
- out_data  out  DATA_WIDTH  head-of-queue word
- mem_wr_en  out  1  to memory wr_en
- mem_wr_addr  out  ADDR_W  to memory wr_addr
- mem_wr_data  out  DATA_WIDTH  to memory wr_data
- mem_rd_en  out  1  to memory rd_en
- mem_rd_addr  out  ADDR_W  to memory rd_addr
- mem_rd_data  in  DATA_WIDTH  from memory rd_data; combinational
- count  out  ADDR_W  words held: memory occupancy + out_valid
- full  out  1  memory occupancy == LINES_NUM
- empty  out  1  count == 0

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_W-bit registers: lower bits index the memory, MSB is the wrap bit.
  - mem_occ = wptr - rptr, modulo 2^ADDR_W.
  - mem_full = (lower bits equal) and (MSB different).
  - mem_empty = (wptr == rptr).
- Memory addresses:
  - mem_wr_addr = {1'b0, wptr lower bits}; mem_rd_addr = {1'b0, rptr lower bits}.
  - The MSB of both addresses is always 0, so no address >= LINES_NUM ever reaches the memory.
- Reset (async) values:
  - wptr = 0, rptr = 0, out_valid = 0, out_data = 0.
  - Resulting outputs: in_ready = 1, full = 0, empty = 1, count = 0, mem_wr_en = 0, mem_rd_en = 0.
  - The memory shares rst and clears itself.
- Push:
  - in_ready = !mem_full, derived from register state only (no combinational path from out_ready).
  - push = in_valid && in_ready.
  - On push: mem_wr_en = 1 and mem_wr_data = in_data in the same cycle; wptr increments at the edge.
- Load (prefetch):
  - load = !mem_empty && (!out_valid || out_ready).
  - mem_rd_en = load.
  - At the edge: out_data <= mem_rd_data, rptr increments, out_valid <= 1.
- Pop:
  - pop = out_valid && out_ready.
  - If pop && !load: out_valid <= 0 and out_data holds its value.
  - out_data is stable while out_valid && !out_ready.
- Latency:
  - Push accepted in cycle 0 → memory written at edge 0 → load in cycle 1 → out_valid in cycle 2.
  - There is no write-to-read bypass.
- Throughput: one push and one pop per cycle sustained, with no bubbles once the memory is non-empty.
- Simultaneous push and load in the same cycle are legal.
  - They are always to different addresses unless the memory is empty, and load is suppressed when it is empty.
- Full: in_ready = 0 while mem_full, even if a load frees a line in that cycle. The slot becomes usable in the next cycle.
- Wrap-around: pointer lower bits go LINES_NUM-1 → 0 and the MSB toggles.
- Reset mid-operation: all queued data is discarded and the block returns to reset values immediately.

Decomposition:
- Package memory_fifo_pkg holds:
  - ADDR_W computation function;
  - occupancy/compare helper functions.
- One natural sub-module, fifo_ptr:
  - ADDR_W-bit wrap-bit pointer with async reset and inc enable;
  - instantiated twice (write and read).

Test Plan:
(LINES_NUM=8, DATA_WIDTH=4)
1. Reset → in_ready=1, out_valid=0, empty=1, full=0, count=0, mem_wr_en=0, mem_rd_en=0, mem addresses 0.
2. Push 0xA in cycle 0, out_ready=0 →
   - cycle 0: mem_wr_en=1, mem_wr_addr=0, mem_wr_data=0xA;
   - cycle 1: mem_rd_en=1, mem_rd_addr=0;
   - cycle 2: out_valid=1, out_data=0xA, count=1.
3. Push 0..8 on consecutive cycles, out_ready=0 →
   - out_data=0, full=1, in_ready=0, count=9;
   - a 10th in_valid is not accepted and mem_wr_en stays 0.
4. From the state of test 3, hold out_ready=1 → out_data is 0,1,…,8 on consecutive cycles; in_ready returns the cycle after the first load; empty=1 after the last pop.
5. Stream 20 words 0..19 (mod 16) with in_valid=1 and out_ready=1 →
   - order is preserved;
   - mem_wr_addr wraps 7→0;
   - the MSB of both mem addresses is always 0;
   - count never exceeds 2.
6. Push 5 words, assert rst mid-stream → all outputs return to reset values at once; after release, push 0x3 → out_data=0x3 is the first word at cycle 2.
